// File: rtl/pipe_shifter.sv
// pipe_shifter: pipelined SLL/SRL/SRA/ROR barrel shifter with valid/ready flow control.
// Define PIPE_SHIFTER_ZERO_FLAG_EN to add the registered o_zero result flag.
module pipe_shifter #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  input  logic [1:0]               i_mode,
  output logic                     o_valid,
  input  logic                     i_ready,
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  output logic                     o_zero,
`endif
  output logic [WIDTH-1:0]         o_data
);

  localparam int SHW = $clog2(WIDTH);
  localparam int L   = (SHW + STAGES - 1) / STAGES;

  typedef enum logic [1:0] {
    MODE_SLL = 2'b00,
    MODE_SRL = 2'b01,
    MODE_SRA = 2'b10,
    MODE_ROR = 2'b11
  } mode_e;

  // Applies the levels owned by stage stg; level index j shifts by 2^(SHW-1-j).
  function automatic logic [WIDTH-1:0] shiftStage(
    input logic [WIDTH-1:0] d,
    input logic [SHW-1:0]   amt,
    input logic [1:0]       mode,
    input logic             sign,
    input int               stg
  );
    logic [WIDTH-1:0] acc;
    int               amount;
    acc = d;
    for (int j = 0; j < SHW; j++) begin
      if (j >= stg * L && j < (stg + 1) * L && amt[SHW-1-j]) begin
        amount = 1 << (SHW - 1 - j);
        case (mode_e'(mode))
          MODE_SLL: acc = acc << amount;
          MODE_SRL: acc = acc >> amount;
          MODE_SRA: acc = (acc >> amount) | (sign ? ~({WIDTH{1'b1}} >> amount) : '0);
          default:  acc = (acc >> amount) | (acc << (WIDTH - amount));
        endcase
      end
    end
    return acc;
  endfunction

  logic [STAGES-1:0][WIDTH-1:0] r_data;
  logic [STAGES-1:0][SHW-1:0]   r_shamt;
  logic [STAGES-1:0][1:0]       r_mode;
  logic [STAGES-1:0]            r_sign;
  logic [STAGES-1:0]            r_valid;

  logic [STAGES-1:0][WIDTH-1:0] w_inData;
  logic [STAGES-1:0][SHW-1:0]   w_inShamt;
  logic [STAGES-1:0][1:0]       w_inMode;
  logic [STAGES-1:0]            w_inSign;
  logic [STAGES-1:0]            w_inValid;
  logic [STAGES-1:0][WIDTH-1:0] w_shifted;
  logic [STAGES:0]              w_adv;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    if (s == 0) begin : g_head
      assign w_inData[s]  = i_data;
      assign w_inShamt[s] = i_shamt;
      assign w_inMode[s]  = i_mode;
      assign w_inSign[s]  = i_data[WIDTH-1];
      assign w_inValid[s] = i_valid;
    end else begin : g_body
      assign w_inData[s]  = r_data[s-1];
      assign w_inShamt[s] = r_shamt[s-1];
      assign w_inMode[s]  = r_mode[s-1];
      assign w_inSign[s]  = r_sign[s-1];
      assign w_inValid[s] = r_valid[s-1];
    end
    assign w_shifted[s] = shiftStage(w_inData[s], w_inShamt[s], w_inMode[s], w_inSign[s], s);
  end

  // A stage may load when it is empty or its contents move on; the chain ends at i_ready.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = i_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_adv[s] = ~r_valid[s] | w_adv[s+1];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      r_data  <= '0;
      r_shamt <= '0;
      r_mode  <= '0;
      r_sign  <= '0;
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (i_flush) begin
          r_valid[s] <= 1'b0;
        end else if (w_adv[s]) begin
          r_valid[s] <= w_inValid[s];
          r_data[s]  <= w_shifted[s];
          r_shamt[s] <= w_inShamt[s];
          r_mode[s]  <= w_inMode[s];
          r_sign[s]  <= w_inSign[s];
        end
      end
    end
  end

`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  logic r_zero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_zero <= 1'b0;
    end else if (i_flush) begin
      r_zero <= 1'b0;
    end else if (w_adv[STAGES-1]) begin
      r_zero <= w_inValid[STAGES-1] && (w_shifted[STAGES-1] == '0);
    end
  end

  assign o_zero = r_zero;
`endif

  // The last stage's control fields have no consumer downstream.
  logic w_unused;
  assign w_unused = ^{r_shamt[STAGES-1], r_mode[STAGES-1], r_sign[STAGES-1]};

  assign o_ready = w_adv[0] | i_flush;
  assign o_valid = r_valid[STAGES-1];
  assign o_data  = r_data[STAGES-1];

endmodule

// File: tb/tb_pipe_shifter.sv
// tb_pipe_shifter: directed checks of pipe_shifter (32/2) plus reference-model sweeps of 64/6 and 8/1.
// Builds with or without PIPE_SHIFTER_ZERO_FLAG_EN.
module tb_pipe_shifter;

  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b10;
  localparam logic [1:0] ROR = 2'b11;

  logic        clk;
  logic        rst;

  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] dataIn;
  logic [4:0]  shamtIn;
  logic [1:0]  modeIn;
  logic        outValid;
  logic        outReady;
  logic [31:0] dataOut;

  logic        valid64;
  logic [63:0] data64;
  logic [5:0]  shamt64;
  logic [1:0]  mode64;
  logic        outValid64;
  logic        outReady64;
  logic [63:0] dataOut64;

  logic        valid8;
  logic [7:0]  data8;
  logic [2:0]  shamt8;
  logic [1:0]  mode8;
  logic        outValid8;
  logic        outReady8;
  logic [7:0]  dataOut8;

`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
  logic        zero32;
  logic        zero64;
  logic        zero8;
`endif

  int nChecks;
  int nPass;

  pipe_shifter #(.WIDTH(32), .STAGES(2)) u_dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (flush),
    .i_valid (inValid),
    .o_ready (outReady),
    .i_data  (dataIn),
    .i_shamt (shamtIn),
    .i_mode  (modeIn),
    .o_valid (outValid),
    .i_ready (inReady),
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    .o_zero  (zero32),
`endif
    .o_data  (dataOut)
  );

  pipe_shifter #(.WIDTH(64), .STAGES(6)) u_dut64 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .i_valid (valid64),
    .o_ready (outReady64),
    .i_data  (data64),
    .i_shamt (shamt64),
    .i_mode  (mode64),
    .o_valid (outValid64),
    .i_ready (1'b1),
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    .o_zero  (zero64),
`endif
    .o_data  (dataOut64)
  );

  pipe_shifter #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_flush (1'b0),
    .i_valid (valid8),
    .o_ready (outReady8),
    .i_data  (data8),
    .i_shamt (shamt8),
    .i_mode  (mode8),
    .o_valid (outValid8),
    .i_ready (1'b1),
`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    .o_zero  (zero8),
`endif
    .o_data  (dataOut8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-by-bit reference: each result bit is picked straight from the operand.
  function automatic logic [63:0] refShift(input int w, input logic [63:0] d,
                                           input int sh, input logic [1:0] mode);
    logic [63:0] r;
    logic        sign;
    r    = '0;
    sign = d[w-1];
    for (int i = 0; i < w; i++) begin
      case (mode)
        SLL:     r[i] = (i >= sh) ? d[i-sh] : 1'b0;
        SRL:     r[i] = (i + sh < w) ? d[i+sh] : 1'b0;
        SRA:     r[i] = (i + sh < w) ? d[i+sh] : sign;
        default: r[i] = d[(i+sh)%w];
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nChecks++;
    assert (observed === expected) nPass++;
    else $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic [4:0] sh, input logic [1:0] m);
    inValid = v;
    dataIn  = d;
    shamtIn = sh;
    modeIn  = m;
    #1;
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic sweep64();
    logic [63:0] d;
    int          sh;
    logic [1:0]  m;
    int          lat;
    for (int n = 0; n < 8; n++) begin
      d  = {$urandom, $urandom};
      sh = (n == 0) ? 0 : (n == 1) ? 63 : $urandom_range(0, 63);
      m  = 2'($urandom_range(0, 3));
      valid64 = 1'b1;
      data64  = d;
      shamt64 = 6'(sh);
      mode64  = m;
      nextCycle();
      valid64 = 1'b0;
      lat = 1;
      while (!outValid64 && lat < 20) begin
        nextCycle();
        lat++;
      end
      checkOutput("sweep64 latency", 64'(lat), 64'd6);
      checkOutput("sweep64 data", dataOut64, refShift(64, d, sh, m));
    end
  endtask

  task automatic sweep8();
    logic [7:0] d;
    int         sh;
    logic [1:0] m;
    int         lat;
    for (int n = 0; n < 10; n++) begin
      d  = 8'($urandom);
      sh = (n == 0) ? 0 : (n == 1) ? 7 : $urandom_range(0, 7);
      m  = (n < 4) ? 2'(n) : 2'($urandom_range(0, 3));
      valid8 = 1'b1;
      data8  = d;
      shamt8 = 3'(sh);
      mode8  = m;
      nextCycle();
      valid8 = 1'b0;
      lat = 1;
      while (!outValid8 && lat < 20) begin
        nextCycle();
        lat++;
      end
      checkOutput("sweep8 latency", 64'(lat), 64'd1);
      checkOutput("sweep8 data", 64'(dataOut8), refShift(8, {56'b0, d}, sh, m));
    end
  endtask

  initial begin
    nChecks = 0;
    nPass   = 0;
    rst     = 1'b1;
    flush   = 1'b0;
    inReady = 1'b1;
    valid64 = 1'b0; data64 = '0; shamt64 = '0; mode64 = '0;
    valid8  = 1'b0; data8  = '0; shamt8  = '0; mode8  = '0;
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);

    // Reset state
    nextCycle();
    checkOutput("reset o_valid", 64'(outValid), 64'd0);
    checkOutput("reset o_data", 64'(dataOut), 64'd0);
    checkOutput("reset o_ready", 64'(outReady), 64'd1);
    rst = 1'b0;

    // Single SRA transaction, latency of two cycles
    $display("[TB] single SRA transaction");
    nextCycle();
    applyStimulus(1'b1, 32'h8000_00F0, 5'd4, SRA);
    checkOutput("sra accept o_ready", 64'(outReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    checkOutput("sra cycle1 o_valid", 64'(outValid), 64'd0);
    nextCycle();
    checkOutput("sra cycle2 o_valid", 64'(outValid), 64'd1);
    checkOutput("sra cycle2 o_data", 64'(dataOut), 64'hF800_000F);
    nextCycle();
    checkOutput("sra drained o_valid", 64'(outValid), 64'd0);

    // Back-to-back stream
    $display("[TB] back-to-back stream");
    applyStimulus(1'b1, 32'h0000_0001, 5'd31, SLL);
    nextCycle();
    applyStimulus(1'b1, 32'h8000_0000, 5'd1, SRL);
    nextCycle();
    checkOutput("stream sll o_valid", 64'(outValid), 64'd1);
    checkOutput("stream sll o_data", 64'(dataOut), 64'h8000_0000);
    applyStimulus(1'b1, 32'h0000_0001, 5'd1, ROR);
    nextCycle();
    checkOutput("stream srl o_valid", 64'(outValid), 64'd1);
    checkOutput("stream srl o_data", 64'(dataOut), 64'h4000_0000);
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    nextCycle();
    checkOutput("stream ror o_valid", 64'(outValid), 64'd1);
    checkOutput("stream ror o_data", 64'(dataOut), 64'h8000_0000);
    nextCycle();
    checkOutput("stream end o_valid", 64'(outValid), 64'd0);

    // Backpressure with three transactions
    $display("[TB] backpressure");
    inReady = 1'b0;
    applyStimulus(1'b1, 32'h0000_00AB, 5'd4, SLL);
    checkOutput("bp t1 o_ready", 64'(outReady), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h1234_5678, 5'd8, SRL);
    checkOutput("bp t2 o_ready", 64'(outReady), 64'd1);
    nextCycle();
    applyStimulus(1'b1, 32'h1234_5678, 5'd16, ROR);
    checkOutput("bp full o_ready", 64'(outReady), 64'd0);
    checkOutput("bp held o_data", 64'(dataOut), 64'h0000_0AB0);
    nextCycle();
    checkOutput("bp stall o_valid", 64'(outValid), 64'd1);
    checkOutput("bp stall o_data", 64'(dataOut), 64'h0000_0AB0);
    checkOutput("bp stall o_ready", 64'(outReady), 64'd0);
    inReady = 1'b1;
    #1;
    checkOutput("bp release o_ready", 64'(outReady), 64'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    checkOutput("bp t2 o_data", 64'(dataOut), 64'h0012_3456);
    nextCycle();
    checkOutput("bp t3 o_valid", 64'(outValid), 64'd1);
    checkOutput("bp t3 o_data", 64'(dataOut), 64'h5678_1234);
    nextCycle();
    checkOutput("bp drained o_valid", 64'(outValid), 64'd0);

    // Flush with two in flight and a third presented
    $display("[TB] flush");
    inReady = 1'b0;
    applyStimulus(1'b1, 32'h0000_0011, 5'd1, SLL);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0022, 5'd2, SLL);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0033, 5'd3, SLL);
    flush = 1'b1;
    #1;
    checkOutput("flush o_ready", 64'(outReady), 64'd1);
    nextCycle();
    checkOutput("flush next o_valid", 64'(outValid), 64'd0);
    flush   = 1'b0;
    inReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    nextCycle();
    checkOutput("flush +2 o_valid", 64'(outValid), 64'd0);
    nextCycle();
    checkOutput("flush +3 o_valid", 64'(outValid), 64'd0);

    // Asynchronous reset between edges
    $display("[TB] async reset");
    inReady = 1'b0;
    applyStimulus(1'b1, 32'hFFFF_0000, 5'd4, SRL);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    nextCycle();
    checkOutput("pre-reset o_data", 64'(dataOut), 64'h0FFF_F000);
    rst = 1'b1;
    #1;
    checkOutput("async reset o_valid", 64'(outValid), 64'd0);
    checkOutput("async reset o_data", 64'(dataOut), 64'd0);
    #1;
    rst     = 1'b0;
    inReady = 1'b1;
    nextCycle();
    applyStimulus(1'b1, 32'h8000_00F0, 5'd4, SRA);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    checkOutput("post-reset cycle1 o_valid", 64'(outValid), 64'd0);
    nextCycle();
    checkOutput("post-reset cycle2 o_valid", 64'(outValid), 64'd1);
    checkOutput("post-reset cycle2 o_data", 64'(dataOut), 64'hF800_000F);
    nextCycle();

`ifdef PIPE_SHIFTER_ZERO_FLAG_EN
    $display("[TB] zero flag");
    applyStimulus(1'b1, 32'h0000_0001, 5'd1, SRL);
    nextCycle();
    applyStimulus(1'b1, 32'h0000_0001, 5'd0, SRL);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 5'd0, SLL);
    checkOutput("zero flag set", 64'(zero32), 64'd1);
    nextCycle();
    checkOutput("zero flag clear", 64'(zero32), 64'd0);
    nextCycle();
    checkOutput("zero flag idle", 64'(zero32), 64'd0);
`endif

    $display("[TB] sweep WIDTH=64 STAGES=6");
    sweep64();
    $display("[TB] sweep WIDTH=8 STAGES=1");
    sweep8();

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
